// File: rtl/sad_sched_pkg.sv
// Shared types and constants for the 16x16 SAD block scheduler.
package sad_sched_pkg;

  // Job addresses are stored at the SRAM address width; the scheduler's ADDR_W must match.
  localparam int SRAM_ADDR_W = 11;

  localparam int          ROWS          = 16;
  localparam int          WORDS_PER_ROW = 2;
  localparam int          READS_PER_JOB = 64;
  localparam logic [15:0] SAD_ERR       = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT_SAD,
    RESP
  } state_e;

  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] addr1;
    logic [SRAM_ADDR_W-1:0] addr2;
    logic [4:0]             id;
  } sad_job_t;

endpackage

// File: rtl/sad_job_fifo.sv
// Synchronous job queue with full/empty flags and a single-cycle flush.
module sad_job_fifo
  import sad_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     push,
  input  logic     pop,
  input  sad_job_t din,
  output sad_job_t dout,
  output logic     full,
  output logic     empty
);

  localparam int PW = $clog2(DEPTH);

  sad_job_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only read once count marks them valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sad_blk_sched.sv
// Queues block-pair jobs, streams both 16x16 blocks from SRAM row by row into the SAD core, returns tagged results.
module sad_blk_sched
  import sad_sched_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr1,
  input  logic [ADDR_W-1:0] cmd_addr2,
  input  logic [4:0]        cmd_id,
  output logic              sram_rd_n,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [63:0]       sram_rdata,
  output logic              sad_vld_in,
  output logic [127:0]      sad_din1,
  output logic [127:0]      sad_din2,
  input  logic              sad_vld,
  input  logic [15:0]       sad,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [4:0]        res_id,
  output logic [15:0]       res_sad,
  output logic              res_err,
  output logic              busy
);

  localparam int          TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [5:0]  RD_LAST  = 6'(READS_PER_JOB - 1);

  state_e            state;
  state_e            state_nxt;
  sad_job_t          fifo_din;
  sad_job_t          fifo_dout;
  sad_job_t          job;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [5:0]        rd_cnt;
  logic [ADDR_W-1:0] base;
  logic              tag_vld;
  logic [1:0]        tag;
  logic [63:0]       d1_lo, d1_hi, d2_lo, d2_hi;
  logic [TW-1:0]     tmo_cnt;
  logic              tmo_hit;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready && !abort;
  assign fifo_din  = '{addr1: cmd_addr1, addr2: cmd_addr2, id: cmd_id};

  sad_job_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:     if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = FETCH;
                  end
        FETCH:    if (rd_cnt == RD_LAST) state_nxt = WAIT_SAD;
        WAIT_SAD: if (sad_vld || tmo_hit) state_nxt = RESP;
        RESP:     if (res_ready) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      job     <= '0;
      rd_cnt  <= '0;
      tmo_cnt <= '0;
    end else begin
      if (pop) job <= fifo_dout;
      rd_cnt  <= (state == FETCH && !abort) ? rd_cnt + 6'd1 : '0;
      tmo_cnt <= (state == WAIT_SAD && !abort) ? tmo_cnt + 1'b1 : '0;
    end
  end

  // rd_cnt = {row[3:0], block, odd}: address = base + 2*row + odd, wrapping at ADDR_W.
  assign base       = rd_cnt[1] ? job.addr2 : job.addr1;
  assign sram_rd_n  = (state != FETCH);
  assign sram_raddr = (state == FETCH) ? base + ADDR_W'({rd_cnt[5:2], rd_cnt[0]}) : '0;

  // The tag follows each read by one cycle so it lines up with the returned word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld <= 1'b0;
      tag     <= '0;
      d1_lo   <= '0;
      d1_hi   <= '0;
      d2_lo   <= '0;
      d2_hi   <= '0;
    end else begin
      tag_vld <= (state == FETCH) && !abort;
      tag     <= rd_cnt[1:0];
      if (tag_vld && !abort) begin
        unique case (tag)
          2'd0: d1_lo <= sram_rdata;
          2'd1: d1_hi <= sram_rdata;
          2'd2: d2_lo <= sram_rdata;
          2'd3: d2_hi <= sram_rdata;
          default: ;
        endcase
      end
    end
  end

  // The row's last word bypasses its register so the row is offered in the cycle it arrives.
  assign sad_vld_in = tag_vld && (tag == 2'd3);
  assign sad_din1   = {d1_hi, d1_lo};
  assign sad_din2   = {sad_vld_in ? sram_rdata : d2_hi, d2_lo};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_id  <= '0;
      res_sad <= '0;
      res_err <= 1'b0;
    end else if (state == WAIT_SAD && !abort) begin
      if (sad_vld) begin
        res_id  <= job.id;
        res_sad <= sad;
        res_err <= 1'b0;
      end else if (tmo_hit) begin
        res_id  <= job.id;
        res_sad <= SAD_ERR;
        res_err <= 1'b1;
      end
    end
  end

  assign res_valid = (state == RESP);
  assign busy      = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sad_blk_sched.sv
// Directed bench for sad_blk_sched: SRAM returns the word index, a stub core answers 8 cycles after the last row.
module tb_sad_blk_sched;

  localparam int CORE_LAT = 8;

  logic         clk;
  logic         rst_n;
  logic         abort;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [10:0]  cmd_addr1;
  logic [10:0]  cmd_addr2;
  logic [4:0]   cmd_id;
  logic         sram_rd_n;
  logic [10:0]  sram_raddr;
  logic [63:0]  sram_rdata;
  logic         sad_vld_in;
  logic [127:0] sad_din1;
  logic [127:0] sad_din2;
  logic         sad_vld;
  logic [15:0]  sad;
  logic         res_valid;
  logic         res_ready;
  logic [4:0]   res_id;
  logic [15:0]  res_sad;
  logic         res_err;
  logic         busy;

  logic stub_vld;
  logic force_vld;
  logic core_on;
  int   pulse_cnt;
  int   cd;
  int   checks;
  int   failures;

  sad_blk_sched #(.ADDR_W(11), .FIFO_DEPTH(4), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .abort      (abort),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr1  (cmd_addr1),
    .cmd_addr2  (cmd_addr2),
    .cmd_id     (cmd_id),
    .sram_rd_n  (sram_rd_n),
    .sram_raddr (sram_raddr),
    .sram_rdata (sram_rdata),
    .sad_vld_in (sad_vld_in),
    .sad_din1   (sad_din1),
    .sad_din2   (sad_din2),
    .sad_vld    (sad_vld),
    .sad        (sad),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_sad    (res_sad),
    .res_err    (res_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM holds its own word index; data appears the cycle after the strobe.
  initial sram_rdata = '0;
  always @(posedge clk) if (!sram_rd_n) sram_rdata <= {53'd0, sram_raddr};

  assign sad     = 16'h0123;
  assign sad_vld = stub_vld | force_vld;

  // Stub core: counts row pulses, answers CORE_LAT cycles after the 16th.
  initial begin
    stub_vld  = 1'b0;
    pulse_cnt = 0;
    cd        = 0;
  end
  always @(negedge clk) begin
    stub_vld = 1'b0;
    if (!busy) begin
      pulse_cnt = 0;
      cd        = 0;
    end else begin
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) stub_vld = 1'b1;
      end
      if (sad_vld_in) begin
        pulse_cnt = pulse_cnt + 1;
        if (pulse_cnt == 16) begin
          pulse_cnt = 0;
          if (core_on) cd = CORE_LAT;
        end
      end
    end
  end

  function automatic logic [10:0] exp_addr(input logic [10:0] a1, input logic [10:0] a2, input int i);
    logic [10:0] b;
    b = ((i % 4) < 2) ? a1 : a2;
    return b + 11'(2 * (i / 4) + (i % 2));
  endfunction

  // Drives one job for one cycle; returns at the negedge after the push edge.
  task automatic push1(input logic [10:0] a1, input logic [10:0] a2, input logic [4:0] id);
    cmd_valid = 1'b1;
    cmd_addr1 = a1;
    cmd_addr2 = a2;
    cmd_id    = id;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_result(input int bound, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (res_valid !== 1'b1 && waited < bound);
    checks++;
    if (res_valid !== 1'b1) begin
      failures++;
      $display("FAIL wait_result got=no_res_valid exp=res_valid_within_%0d", bound);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (sram_rd_n !== 1'b1 || sram_raddr !== 11'd0) begin
      failures++;
      $display("FAIL reset_sram got=%b/%0d exp=1/0", sram_rd_n, sram_raddr);
    end
    checks++;
    if (sad_vld_in !== 1'b0 || sad_din1 !== '0 || sad_din2 !== '0) begin
      failures++;
      $display("FAIL reset_sad got=%b/%h/%h exp=0/0/0", sad_vld_in, sad_din1, sad_din2);
    end
    checks++;
    if (res_valid !== 1'b0 || res_id !== 5'd0 || res_sad !== 16'd0 || res_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_res got=%b/%0d/%h/%b exp=0/0/0/0", res_valid, res_id, res_sad, res_err);
    end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags got=busy%b/ready%b exp=busy0/ready1", busy, cmd_ready);
    end
  endtask

  task automatic test_single;
    int pulses;
    int waited;
    res_ready = 1'b0;
    push1(11'd0, 11'd32, 5'd7);
    checks++;
    if (sram_rd_n !== 1'b1) begin
      failures++;
      $display("FAIL single_pop_cycle got=rd_n%b exp=rd_n1", sram_rd_n);
    end
    @(negedge clk);
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (sram_rd_n !== 1'b0 || sram_raddr !== exp_addr(11'd0, 11'd32, i)) begin
        failures++;
        $display("FAIL single_read%0d got=%b/%0d exp=0/%0d", i, sram_rd_n, sram_raddr, exp_addr(11'd0, 11'd32, i));
      end
      checks++;
      if (sad_vld_in !== (i >= 4 && i % 4 == 0)) begin
        failures++;
        $display("FAIL single_vld_in_F+%0d got=%b exp=%b", i, sad_vld_in, (i >= 4 && i % 4 == 0));
      end
      if (sad_vld_in === 1'b1) pulses++;
      if (i == 4) begin
        checks++;
        if (sad_din1 !== {64'd1, 64'd0} || sad_din2 !== {64'd33, 64'd32}) begin
          failures++;
          $display("FAIL single_row0 got=%h/%h exp=%h/%h", sad_din1, sad_din2, {64'd1, 64'd0}, {64'd33, 64'd32});
        end
      end
      @(negedge clk);
    end
    checks++;
    if (sad_vld_in !== 1'b1 || sram_rd_n !== 1'b1 || sad_din1 !== {64'd31, 64'd30}) begin
      failures++;
      $display("FAIL single_last_row got=%b/%b/%h exp=1/1/%h", sad_vld_in, sram_rd_n, sad_din1, {64'd31, 64'd30});
    end
    if (sad_vld_in === 1'b1) pulses++;
    checks++;
    if (pulses != 16) begin
      failures++;
      $display("FAIL single_pulses got=%0d exp=16", pulses);
    end
    waited = 0;
    for (int j = 65; j <= 73; j++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== (j == 73)) begin
        failures++;
        $display("FAIL single_res_valid_F+%0d got=%b exp=%b", j, res_valid, (j == 73));
      end
    end
    checks++;
    if (res_id !== 5'd7 || res_sad !== 16'h0123 || res_err !== 1'b0) begin
      failures++;
      $display("FAIL single_result got=%0d/%h/%b exp=7/0123/0", res_id, res_sad, res_err);
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_release got=%b/%b exp=0/0", res_valid, busy);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_wrap;
    logic [10:0] wexp [8];
    int waited;
    wexp = '{11'd2046, 11'd2047, 11'd100, 11'd101, 11'd0, 11'd1, 11'd102, 11'd103};
    res_ready = 1'b1;
    push1(11'd2046, 11'd100, 5'd3);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sram_raddr !== wexp[i]) begin
        failures++;
        $display("FAIL wrap_read%0d got=%0d exp=%0d", i, sram_raddr, wexp[i]);
      end
      if (i == 4) begin
        checks++;
        if (sad_din1 !== {64'd2047, 64'd2046}) begin
          failures++;
          $display("FAIL wrap_row0 got=%h exp=%h", sad_din1, {64'd2047, 64'd2046});
        end
      end
      @(negedge clk);
    end
    wait_result(200, waited);
    checks++;
    if (res_id !== 5'd3 || res_sad !== 16'h0123 || res_err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_result got=%0d/%h/%b exp=3/0123/0", res_id, res_sad, res_err);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    res_ready = 1'b0;
    core_on   = 1'b0;
    push1(11'd0, 11'd32, 5'd9);
    @(negedge clk);
    repeat (127) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early got=%b exp=0", res_valid);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_id !== 5'd9 || res_sad !== 16'hFFFF || res_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_result got=%b/%0d/%h/%b exp=1/9/ffff/1", res_valid, res_id, res_sad, res_err);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    core_on   = 1'b1;
  endtask

  task automatic test_back_to_back;
    int waited;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready%0d got=%b exp=1", i, cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_addr1 = 11'(100 * i);
      cmd_addr2 = 11'(100 * i + 50);
      cmd_id    = 5'(i);
      @(negedge clk);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_full got=%b exp=0", cmd_ready);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_result(300, waited);
      checks++;
      if (res_id !== 5'(i) || res_sad !== 16'h0123 || res_err !== 1'b0) begin
        failures++;
        $display("FAIL b2b_result%0d got=%0d/%h/%b exp=%0d/0123/0", i, res_id, res_sad, res_err, i);
      end
      if (i > 0) begin
        checks++;
        if (waited != 75) begin
          failures++;
          $display("FAIL b2b_spacing%0d got=%0d exp=75", i, waited);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_hold;
    int waited;
    res_ready = 1'b0;
    push1(11'd0, 11'd32, 5'd1);
    push1(11'd40, 11'd80, 5'd2);
    wait_result(200, waited);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_id !== 5'd1 || res_sad !== 16'h0123 || sram_rd_n !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold%0d got=%b/%0d/%h/%b/%b exp=1/1/0123/1/1", i, res_valid, res_id, res_sad, sram_rd_n, busy);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_release got=%b exp=0", res_valid);
    end
    @(negedge clk);
    checks++;
    if (sram_rd_n !== 1'b0 || sram_raddr !== 11'd40) begin
      failures++;
      $display("FAIL hold_next_fetch got=%b/%0d exp=0/40", sram_rd_n, sram_raddr);
    end
    wait_result(200, waited);
    checks++;
    if (res_id !== 5'd2) begin
      failures++;
      $display("FAIL hold_second_id got=%0d exp=2", res_id);
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    res_ready = 1'b1;
    push1(11'd0, 11'd32, 5'd4);
    cmd_valid = 1'b1;
    cmd_id    = 5'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_id    = 5'd6;
    @(negedge clk);
    abort     = 1'b0;
    cmd_valid = 1'b0;
    checks++;
    if (sram_rd_n !== 1'b1 || sad_vld_in !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_next got=%b/%b/%b/%b/%b exp=1/0/0/1/0", sram_rd_n, sad_vld_in, busy, cmd_ready, res_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (sram_rd_n !== 1'b1 || sad_vld_in !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_idle%0d got=%b/%b/%b exp=1/0/0", i, sram_rd_n, sad_vld_in, busy);
      end
    end
    force_vld = 1'b1;
    @(negedge clk);
    force_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_late_vld got=%b/%b exp=0/0", res_valid, busy);
    end
  endtask

  task automatic test_reset_mid_fetch;
    res_ready = 1'b1;
    push1(11'd0, 11'd32, 5'd8);
    @(negedge clk);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (sram_rd_n !== 1'b1 || sad_vld_in !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_flags got=%b/%b/%b/%b exp=1/0/0/1", sram_rd_n, sad_vld_in, busy, cmd_ready);
    end
    checks++;
    if (sad_din1 !== '0 || sad_din2 !== '0 || res_sad !== 16'd0) begin
      failures++;
      $display("FAIL rst_mid_data got=%h/%h/%h exp=0/0/0", sad_din1, sad_din2, res_sad);
    end
    repeat (4) @(negedge clk);
    force_vld = 1'b1;
    @(negedge clk);
    force_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || sram_rd_n !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_late_vld got=%b/%b/%b exp=0/0/1", res_valid, busy, sram_rd_n);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    abort     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr1 = '0;
    cmd_addr2 = '0;
    cmd_id    = '0;
    res_ready = 1'b0;
    force_vld = 1'b0;
    core_on   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_single;
    test_wrap;
    test_timeout;
    test_back_to_back;
    test_hold;
    test_abort;
    test_reset_mid_fetch;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
